dm_param: RTL and testbench

- Parametrised, byte-addressed 32-bit data memory for the datapath; successor to the fixed 64-word data memory.
- Supports byte/half/word loads with sign or zero extension and byte-lane stores.
- Adds misalignment detection, registered read with a valid strobe, and a real load-reserved/store-conditional reservation.
- Adds an optional post-reset clear sequencer.
- Sits between the ALU address path and the writeback mux.

---
 rtl/dm_param_if.sv | 26 ++
 rtl/dm_param.sv | 217 +++++++++++++++++++++
 tb/tb_dm_param.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_param_if.sv
// Request/response bundle for the parametrised data memory.
// The master drives a request; the slave returns ready, load data and status pulses.
interface dm_param_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [1:0]        op;
    logic [1:0]        size;
    logic              unsgn;
    logic [ADDR_W-1:0] ad;
    logic [31:0]       wr_data;
    logic              ready;
    logic              rd_valid;
    logic [31:0]       dm;
    logic              misalign;

    modport master (
        output req, op, size, unsgn, ad, wr_data,
        input  ready, rd_valid, dm, misalign
    );

    modport slave (
        input  req, op, size, unsgn, ad, wr_data,
        output ready, rd_valid, dm, misalign
    );
endinterface

// File: rtl/dm_param.sv
// Parametrised byte-addressed 32-bit data memory with sized loads/stores,
// misalignment detection, a registered read port, an LR/SC reservation and
// an optional post-reset clear sequencer.
module dm_param #(
    parameter int DEPTH          = 64,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_param_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_LR    = 2'd2;
    localparam logic [1:0] OP_SC    = 2'd3;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   clr_ptr_r;
    logic [31:0]        mem_r [DEPTH];
    logic [31:0]        dm_r;
    logic [31:0]        dm_s;
    logic               rd_valid_r;
    logic               rd_valid_s;
    logic               misalign_r;
    logic               misalign_s;
    logic               resv_valid_r;
    logic               resv_valid_s;
    logic [IDX_W-1:0]   resv_addr_r;
    logic [IDX_W-1:0]   resv_addr_s;

    logic [IDX_W-1:0]   idx_s;
    logic [1:0]         lane_s;
    logic               accept_s;
    logic [31:0]        rd_word_s;
    logic               word_sz_s;
    logic               misal_s;
    logic               resv_hit_s;
    logic [3:0]         be_s;
    logic [31:0]        wd_s;
    logic               mem_we_s;

    // Pick the addressed lane(s) out of a word and sign/zero extend them.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        unsgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = unsgn ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    r = unsgn ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Address bits above the word index are deliberately ignored (wrap-around).
    generate
        if (ADDR_W > IDX_W + 2) begin : g_hi
            logic unused_hi_s;
            assign unused_hi_s = ^bus.ad[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    assign idx_s     = bus.ad[IDX_W+1:2];
    assign lane_s    = bus.ad[1:0];
    assign accept_s  = bus.req && (state_r == ST_IDLE);
    assign rd_word_s = mem_r[idx_s];

    // Decode access width, alignment, reservation match and store lane enables.
    always_comb begin
        word_sz_s  = bus.op[1] || bus.size[1];
        resv_hit_s = resv_valid_r && (resv_addr_r == idx_s);
        if (word_sz_s) begin
            misal_s = (lane_s != 2'b00);
        end else if (bus.size == 2'd1) begin
            misal_s = lane_s[0];
        end else begin
            misal_s = 1'b0;
        end
        if (word_sz_s) begin
            be_s = 4'b1111;
            wd_s = bus.wr_data;
        end else if (bus.size == 2'd1) begin
            be_s = lane_s[1] ? 4'b1100 : 4'b0011;
            wd_s = {2{bus.wr_data[15:0]}};
        end else begin
            be_s = 4'b0001 << lane_s;
            wd_s = {4{bus.wr_data[7:0]}};
        end
        mem_we_s = accept_s && !misal_s &&
                   ((bus.op == OP_STORE) || ((bus.op == OP_SC) && resv_hit_s));
    end

    // Next-state logic: sweep every word once in CLEAR, then serve requests.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_ptr_r == IDX_W'(DEPTH - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_IDLE:  state_s = ST_IDLE;
            default:  state_s = RST_STATE;
        endcase
    end

    // Response and reservation next values for an accepted request.
    always_comb begin
        dm_s         = dm_r;
        rd_valid_s   = 1'b0;
        misalign_s   = 1'b0;
        resv_valid_s = resv_valid_r;
        resv_addr_s  = resv_addr_r;
        if (accept_s) begin
            if (misal_s) begin
                misalign_s = 1'b1;
                if (bus.op != OP_STORE) begin
                    rd_valid_s = 1'b1;
                    dm_s       = 32'h0000_0000;
                end else begin
                    rd_valid_s = 1'b0;
                end
            end else begin
                case (bus.op)
                    OP_LOAD: begin
                        rd_valid_s = 1'b1;
                        dm_s       = load_extract(rd_word_s, lane_s, bus.size, bus.unsgn);
                    end
                    OP_STORE: begin
                        if (resv_hit_s) begin
                            resv_valid_s = 1'b0;
                        end else begin
                            resv_valid_s = resv_valid_r;
                        end
                    end
                    OP_LR: begin
                        rd_valid_s   = 1'b1;
                        dm_s         = rd_word_s;
                        resv_valid_s = 1'b1;
                        resv_addr_s  = idx_s;
                    end
                    OP_SC: begin
                        rd_valid_s   = 1'b1;
                        dm_s         = resv_hit_s ? 32'h0000_0000 : 32'h0000_0001;
                        resv_valid_s = 1'b0;
                    end
                    default: begin
                        rd_valid_s = 1'b0;
                    end
                endcase
            end
        end else begin
            dm_s = dm_r;
        end
    end

    // Control state, clear pointer, registered outputs and reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RST_STATE;
            clr_ptr_r    <= '0;
            dm_r         <= 32'h0000_0000;
            rd_valid_r   <= 1'b0;
            misalign_r   <= 1'b0;
            resv_valid_r <= 1'b0;
            resv_addr_r  <= '0;
        end else begin
            state_r      <= state_s;
            if (state_r == ST_CLEAR) begin
                clr_ptr_r <= clr_ptr_r + IDX_W'(1);
            end
            dm_r         <= dm_s;
            rd_valid_r   <= rd_valid_s;
            misalign_r   <= misalign_s;
            resv_valid_r <= resv_valid_s;
            resv_addr_r  <= resv_addr_s;
        end
    end

    // Storage array: clear sweep or byte-lane write; no reset so it maps to RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_ptr_r] <= 32'h0000_0000;
            end else if (mem_we_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_s[i]) begin
                        mem_r[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
                    end
                end
            end
        end
    end

    assign bus.ready    = (state_r == ST_IDLE);
    assign bus.rd_valid = rd_valid_r;
    assign bus.dm       = dm_r;
    assign bus.misalign = misalign_r;
endmodule

// File: tb/tb_dm_param.sv
// Scoreboard bench for dm_param: a byte-array reference model predicts each
// response at issue time; a negedge monitor pops and compares on the cycle
// the response is due and checks that no stray pulses appear otherwise.
module tb_dm_param;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dm_param_if #(.ADDR_W(ADDR_W)) bus ();

    dm_param #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          stamp;
        bit          rv;
        logic [31:0] dm;
        bit          mis;
    } exp_t;

    exp_t         q[$];
    int           ncyc   = 0;
    int           errors = 0;
    int           checks = 0;
    byte unsigned mb [4*DEPTH];
    bit           resv_v = 1'b0;
    int           resv_i = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat byte array, reservation as flag+index.
    task automatic model(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output bit out, output bit rv, output logic [31:0] dmv, output bit mis);
        int idx;
        int base;
        int ln;
        int v;
        int hb;
        int nb;
        int st;
        bit wsz;
        logic [31:0] w;
        idx  = int'((ad >> 2) % DEPTH);
        base = idx * 4;
        ln   = int'(ad % 4);
        wsz  = (op >= 2'd2) || (size >= 2'd2);
        w    = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
        mis  = wsz ? (ln != 0) : ((size == 2'd1) && (ln % 2 == 1));
        out  = 1'b0;
        rv   = 1'b0;
        dmv  = 32'h0;
        if (mis) begin
            out = 1'b1;
            rv  = (op != 2'd1);
            return;
        end
        case (op)
            2'd0: begin
                out = 1'b1;
                rv  = 1'b1;
                if (wsz) begin
                    dmv = w;
                end else if (size == 2'd0) begin
                    v   = int'(mb[base+ln]);
                    dmv = (!uns && v >= 128) ? v - 256 : v;
                end else begin
                    hb  = base + (ln / 2) * 2;
                    v   = int'(mb[hb]) + 256 * int'(mb[hb+1]);
                    dmv = (!uns && v >= 32768) ? v - 65536 : v;
                end
            end
            2'd1: begin
                nb = wsz ? 4 : ((size == 2'd0) ? 1 : 2);
                st = wsz ? 0 : ((size == 2'd0) ? ln : (ln / 2) * 2);
                for (int k = 0; k < nb; k++) mb[base+st+k] = wd[8*k +: 8];
                if (resv_v && resv_i == idx) resv_v = 1'b0;
            end
            2'd2: begin
                out    = 1'b1;
                rv     = 1'b1;
                dmv    = w;
                resv_v = 1'b1;
                resv_i = idx;
            end
            default: begin
                out = 1'b1;
                rv  = 1'b1;
                if (resv_v && resv_i == idx) begin
                    for (int k = 0; k < 4; k++) mb[base+k] = wd[8*k +: 8];
                    dmv = 32'h0;
                end else begin
                    dmv = 32'h1;
                end
                resv_v = 1'b0;
            end
        endcase
    endtask

    // mode 0: expect model value; 1: expect literal lit; 2: update model only.
    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input int mode, input logic [31:0] lit);
        bit out;
        bit rv;
        bit mis;
        logic [31:0] dmv;
        exp_t e;
        model(op, size, uns, ad, wd, out, rv, dmv, mis);
        bus.req     = 1'b1;
        bus.op      = op;
        bus.size    = size;
        bus.unsgn   = uns;
        bus.ad      = ad;
        bus.wr_data = wd;
        if (out && mode != 2) begin
            e.stamp = ncyc + 2;
            e.rv    = rv;
            e.mis   = mis;
            e.dm    = (mode == 1) ? lit : dmv;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        q.delete();
        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
        resv_v = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_dm", bus.dm, 32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        #3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ready) break;
            n++;
        end
        chk("clear_cycles", n, 64);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the due response, otherwise require quiet outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            while (q.size() > 0 && q[0].stamp < ncyc) begin
                e = q.pop_front();
                errors++;
                checks++;
                $display("FAIL late_response: got none expected stamp %0d (now %0d)", e.stamp, ncyc);
            end
            if (q.size() > 0 && q[0].stamp == ncyc) begin
                e = q.pop_front();
                chk("rd_valid", 32'(bus.rd_valid), 32'(e.rv));
                chk("misalign", 32'(bus.misalign), 32'(e.mis));
                if (e.rv) chk("dm", bus.dm, e.dm);
            end else if (rst_n) begin
                chk("quiet_rd_valid", 32'(bus.rd_valid), 32'd0);
                chk("quiet_misalign", 32'(bus.misalign), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] ad;
        int          ln;
        bus.req     = 1'b0;
        bus.op      = 2'd0;
        bus.size    = 2'd0;
        bus.unsgn   = 1'b0;
        bus.ad      = 32'h0;
        bus.wr_data = 32'h0;

        do_reset();
        issue(2'd0, 2'd2, 1'b0, 32'h0000_00FC, 32'h0, 1, 32'h0000_0000);

        issue(2'd1, 2'd2, 1'b0, 32'h0000_0010, 32'h8081_F2F3, 0, 32'h0);
        issue(2'd0, 2'd0, 1'b0, 32'h0000_0012, 32'h0, 1, 32'hFFFF_FF81);
        issue(2'd0, 2'd0, 1'b1, 32'h0000_0012, 32'h0, 1, 32'h0000_0081);
        issue(2'd0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 1, 32'hFFFF_FF80);
        issue(2'd0, 2'd1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hFFFF_F2F3);

        issue(2'd1, 2'd2, 1'b0, 32'h0000_0020, 32'h1122_3344, 0, 32'h0);
        issue(2'd1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_00AA, 0, 32'h0);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 1, 32'h1122_AA44);
        issue(2'd1, 2'd1, 1'b0, 32'h0000_0023, 32'h0000_BEEF, 0, 32'h0);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 1, 32'h1122_AA44);

        issue(2'd2, 2'd0, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_0000);
        issue(2'd3, 2'd2, 1'b0, 32'h0000_0040, 32'h5, 1, 32'h0000_0000);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_0005);
        issue(2'd3, 2'd2, 1'b0, 32'h0000_0040, 32'h6, 1, 32'h0000_0001);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_0005);

        issue(2'd2, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_0005);
        issue(2'd1, 2'd0, 1'b0, 32'h0000_0043, 32'h0000_0077, 0, 32'h0);
        issue(2'd3, 2'd2, 1'b0, 32'h0000_0040, 32'h8, 1, 32'h0000_0001);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h7700_0005);
        issue(2'd2, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h7700_0005);
        issue(2'd1, 2'd2, 1'b0, 32'h0000_0044, 32'h1234_5678, 0, 32'h0);
        issue(2'd3, 2'd2, 1'b0, 32'h0000_0040, 32'h9, 1, 32'h0000_0000);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_0009);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                op   = 2'($urandom_range(0, 3));
                size = 2'($urandom_range(0, 3));
                ln   = $urandom_range(0, 3);
                if ((op >= 2'd2 || size >= 2'd2) && $urandom_range(0, 3) != 0) ln = 0;
                ad = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'(ln);
                issue(op, size, 1'($urandom_range(0, 1)), ad, $urandom, 0, 32'h0);
            end
        end
        idle(3);

        issue(2'd2, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 2, 32'h0);
        chk("midrst_rd_valid_before", 32'(bus.rd_valid), 32'd1);
        chk("midrst_dm_before", bus.dm, 32'h0000_0009);
        do_reset();
        issue(2'd3, 2'd2, 1'b0, 32'h0000_0040, 32'h7, 1, 32'h0000_0001);
        issue(2'd0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0000_0000);
        idle(3);
        chk("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
